// File: rtl/sevenseg_rx_if.sv
// Scan-line bundle between a seven-segment transmitter and sevenseg_rx.
// The master drives the scanned an_n/segs_n/dp_n lines and observes the
// recovered digits. The slave, which is the receiver, does the opposite.
interface sevenseg_rx_if;
  logic [7:0] an_n;
  logic [6:0] segs_n;
  logic       dp_n;
  logic [6:0] d0;
  logic [6:0] d1;
  logic [6:0] d2;
  logic [6:0] d3;
  logic [6:0] d4;
  logic [6:0] d5;
  logic [6:0] d6;
  logic [6:0] d7;
  logic [7:0] valid;
  logic       frame_done;
  logic       err;

  modport master (
    output an_n, segs_n, dp_n,
    input  d0, d1, d2, d3, d4, d5, d6, d7, valid, frame_done, err
  );

  modport slave (
    input  an_n, segs_n, dp_n,
    output d0, d1, d2, d3, d4, d5, d6, d7, valid, frame_done, err
  );
endinterface

// File: rtl/sevenseg_rx.sv
// sevenseg_rx: receive side of a multiplexed 8-digit seven-segment link.
// The module synchronises the scanned anode, segment and dp lines. It waits
// for them to settle and then decodes the active digit into the
// {blank,dp,dash,hex} code format.
// Optional build macro SEVENSEG_RX_TIMEOUT_EN adds a timeout. When the
// timeout expires because no good capture has arrived, all valid bits and
// the frame mask are dropped.
module sevenseg_rx #(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  sevenseg_rx_if.slave bus
);

  localparam int unsigned     CNT_W      = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SETTLE_CYC - 1);
  localparam logic [6:0]      CODE_BLANK = 7'b100_0000;

  // Decode an active-high segment pattern plus dp.
  // Bit 7 of the result is set for a legal pattern. Bits 6:0 hold the code.
  function automatic logic [7:0] decode_fn(input logic [6:0] p, input logic dpb);
    logic [7:0] r;
    logic [3:0] h;
    logic       hit;
    h   = 4'h0;
    hit = 1'b1;
    case (p)
      7'h3F:   h = 4'h0;
      7'h06:   h = 4'h1;
      7'h5B:   h = 4'h2;
      7'h4F:   h = 4'h3;
      7'h66:   h = 4'h4;
      7'h6D:   h = 4'h5;
      7'h7D:   h = 4'h6;
      7'h07:   h = 4'h7;
      7'h7F:   h = 4'h8;
      7'h6F:   h = 4'h9;
      7'h77:   h = 4'hA;
      7'h7C:   h = 4'hB;
      7'h39:   h = 4'hC;
      7'h5E:   h = 4'hD;
      7'h79:   h = 4'hE;
      7'h71:   h = 4'hF;
      default: hit = 1'b0;
    endcase
    if (p == 7'h00) begin
      // A lone decimal point with no segments lit is not a legal code.
      r = dpb ? 8'h00 : {1'b1, CODE_BLANK};
    end else if (p == 7'h40) begin
      r = {1'b1, 1'b0, dpb, 1'b1, 4'h0};
    end else if (hit) begin
      r = {1'b1, 1'b0, dpb, 1'b0, h};
    end else begin
      r = 8'h00;
    end
    return r;
  endfunction

  logic [15:0]      raw_s;
  logic [15:0]      sync1_r;
  logic [15:0]      sync2_r;
  logic [15:0]      prev_r;
  logic [7:0]       an_s;
  logic [6:0]       segs_s;
  logic             dp_s;
  logic             change_s;
  logic             an_change_s;
  logic [CNT_W-1:0] cnt_r;
  logic             captured_r;
  logic [7:0]       act_s;
  logic             single_s;
  logic             multi_s;
  logic [2:0]       idx_s;
  logic [7:0]       dec_s;
  logic             capture_s;
  logic             good_s;
  logic             bad_s;
  logic [7:0]       set_bit_s;
  logic [7:0]       clr_bit_s;
  logic [7:0]       mask_base_s;
  logic [7:0]       mask_next_s;
  logic [7:0]       valid_next_s;
  logic             frame_s;
  logic             timeout_s;
  logic [7:0]       mask_r;
  logic [7:0]       valid_r;
  logic [6:0]       d_r [8];
  logic             frame_r;
  logic             err_r;

  assign raw_s       = {bus.an_n, bus.segs_n, bus.dp_n};
  assign an_s        = sync2_r[15:8];
  assign segs_s      = sync2_r[7:1];
  assign dp_s        = sync2_r[0];
  assign change_s    = (sync2_r != prev_r);
  assign an_change_s = (sync2_r[15:8] != prev_r[15:8]);

  // Classify the synced anodes as idle, a single active digit, or several digits.
  always_comb begin
    act_s    = ~an_s;
    idx_s    = 3'd0;
    single_s = 1'b1;
    case (an_s)
      8'hFE:   idx_s = 3'd0;
      8'hFD:   idx_s = 3'd1;
      8'hFB:   idx_s = 3'd2;
      8'hF7:   idx_s = 3'd3;
      8'hEF:   idx_s = 3'd4;
      8'hDF:   idx_s = 3'd5;
      8'hBF:   idx_s = 3'd6;
      8'h7F:   idx_s = 3'd7;
      default: single_s = 1'b0;
    endcase
    multi_s = (act_s != 8'h00) && !single_s;
  end

  // Capture decision, decode, and next frame-mask / valid computation.
  always_comb begin
    dec_s     = decode_fn(~segs_s, ~dp_s);
    capture_s = (cnt_r == CNT_MAX) && !change_s && single_s && !captured_r;
    good_s    = capture_s && dec_s[7];
    bad_s     = capture_s && !dec_s[7];
    set_bit_s = good_s ? (8'h01 << idx_s) : 8'h00;
    clr_bit_s = bad_s  ? (8'h01 << idx_s) : 8'h00;
    if (timeout_s) begin
      mask_base_s = 8'h00;
    end else begin
      mask_base_s = mask_r;
    end
    frame_s = good_s && ((mask_base_s | set_bit_s) == 8'hFF);
    if (frame_s) begin
      mask_next_s = 8'h00;
    end else begin
      mask_next_s = mask_base_s | set_bit_s;
    end
    if (timeout_s) begin
      valid_next_s = set_bit_s;
    end else begin
      valid_next_s = (valid_r | set_bit_s) & ~clr_bit_s;
    end
  end

  // Synchroniser, settle counter, capture bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r    <= 16'hFFFF;
      sync2_r    <= 16'hFFFF;
      prev_r     <= 16'hFFFF;
      cnt_r      <= '0;
      captured_r <= 1'b0;
      mask_r     <= 8'h00;
      valid_r    <= 8'h00;
      frame_r    <= 1'b0;
      err_r      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        d_r[i] <= CODE_BLANK;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      if (change_s) begin
        cnt_r <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (change_s) begin
        captured_r <= 1'b0;
      end else if (capture_s) begin
        captured_r <= 1'b1;
      end else begin
        captured_r <= captured_r;
      end
      if (good_s) begin
        d_r[idx_s] <= dec_s[6:0];
      end
      mask_r  <= mask_next_s;
      valid_r <= valid_next_s;
      frame_r <= frame_s;
      err_r   <= bad_s || (multi_s && an_change_s);
    end
  end

`ifdef SEVENSEG_RX_TIMEOUT_EN
  localparam int unsigned      TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_r;

  assign timeout_s = (to_cnt_r == TO_MAX);

  // Idle counter: restarts on each good capture and holds once it expires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
    end else if (good_s) begin
      to_cnt_r <= '0;
    end else if (to_cnt_r != TO_MAX) begin
      to_cnt_r <= to_cnt_r + 1'b1;
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end
`else
  logic unused_timeout_s;

  assign timeout_s        = 1'b0;
  assign unused_timeout_s = ^TIMEOUT_CYC;
`endif

  assign bus.d0         = d_r[0];
  assign bus.d1         = d_r[1];
  assign bus.d2         = d_r[2];
  assign bus.d3         = d_r[3];
  assign bus.d4         = d_r[4];
  assign bus.d5         = d_r[5];
  assign bus.d6         = d_r[6];
  assign bus.d7         = d_r[7];
  assign bus.valid      = valid_r;
  assign bus.frame_done = frame_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_sevenseg_rx.sv
// Self-checking bench for sevenseg_rx. Table-driven digit vectors go through
// a scoreboard queue. Hand-written sequences cover settle latency, glitches,
// multi-anode errors and the idle timeout.
module tb_sevenseg_rx;
  localparam int SETTLE = 16;
  localparam int LAT    = 2 + SETTLE + 1;
  localparam int TO     = 1000;

  typedef struct {
    logic [7:0] an_n;
    logic [6:0] segs_n;
    logic       dp_n;
    int         k;
    logic [6:0] code;
    logic       vbit;
    int         errs;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sevenseg_rx_if bus_if ();

  sevenseg_rx #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int cyc       = 0;
  int err_cnt   = 0;
  int frame_cnt = 0;
  int frame_cyc = -1;
  int pass_cnt  = 0;
  int chk_cnt   = 0;

  logic [6:0] hex_pat [16];
  vec_t       exp_q [$];
  vec_t       tbl_a [$];
  vec_t       tbl_b [$];

  // Cycle counter: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor for err and frame_done, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus_if.err === 1'b1) err_cnt <= err_cnt + 1;
    if (bus_if.frame_done === 1'b1) begin
      frame_cnt <= frame_cnt + 1;
      frame_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic wait_cyc(input int m);
    while (cyc < m) @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] a, input logic [6:0] s, input logic d);
    bus_if.an_n   = a;
    bus_if.segs_n = s;
    bus_if.dp_n   = d;
  endtask

  function automatic logic [6:0] get_d(input int k);
    case (k)
      0:       return bus_if.d0;
      1:       return bus_if.d1;
      2:       return bus_if.d2;
      3:       return bus_if.d3;
      4:       return bus_if.d4;
      5:       return bus_if.d5;
      6:       return bus_if.d6;
      7:       return bus_if.d7;
      default: return 7'h7F;
    endcase
  endfunction

  // Drive one vector, queue its expectation, then pop and compare after the dwell.
  task automatic run_vec(input vec_t v, input int dwell, input string tag);
    int   t0;
    int   e0;
    vec_t e;
    t0 = cyc;
    e0 = err_cnt;
    drive(v.an_n, v.segs_n, v.dp_n);
    exp_q.push_back(v);
    wait_cyc(t0 + dwell);
    e = exp_q.pop_front();
    check($sformatf("%s_d%0d", tag, e.k), {25'd0, get_d(e.k)}, {25'd0, e.code});
    check($sformatf("%s_valid%0d", tag, e.k), {31'd0, bus_if.valid[e.k]}, {31'd0, e.vbit});
    check($sformatf("%s_err%0d", tag, e.k), err_cnt - e0, e.errs);
  endtask

  initial begin
    int         t;
    int         t7;
    int         e0;
    int         f0;
    logic [7:0] vsnap;
    logic [6:0] dsnap [8];
    logic [6:0] glitch [6];

    hex_pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int k = 0; k < 8; k++) begin
      tbl_a.push_back('{~(8'h01 << k), ~hex_pat[k], 1'b1, k, 7'(k), 1'b1, 0});
    end
    tbl_b.push_back('{8'hFB, ~7'h40, 1'b0, 2, 7'h30, 1'b1, 0});
    tbl_b.push_back('{8'hFB, 7'h7F,  1'b1, 2, 7'h40, 1'b1, 0});
    tbl_b.push_back('{8'hFE, ~7'h77, 1'b0, 0, 7'h2A, 1'b1, 0});
    tbl_b.push_back('{8'hFD, ~7'h71, 1'b1, 1, 7'h0F, 1'b1, 0});
    tbl_b.push_back('{8'hEF, ~7'h7C, 1'b1, 4, 7'h0B, 1'b1, 0});
    tbl_b.push_back('{8'hDF, ~7'h01, 1'b1, 5, 7'h05, 1'b0, 1});
    tbl_b.push_back('{8'hBF, 7'h7F,  1'b0, 6, 7'h06, 1'b0, 1});
    tbl_b.push_back('{8'h7F, ~7'h79, 1'b0, 7, 7'h2E, 1'b1, 0});
    glitch = '{7'h06, 7'h5B, 7'h66, 7'h6D, 7'h7D, 7'h7F};

    // Test 1: reset state.
    rst_n = 1'b0;
    drive(8'hFF, 7'h7F, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rst_d%0d", k), {25'd0, get_d(k)}, 32'h40);
    end
    check("rst_valid", {24'd0, bus_if.valid}, 32'h0);
    check("rst_frame", {31'd0, bus_if.frame_done}, 32'h0);
    check("rst_err", {31'd0, bus_if.err}, 32'h0);
    rst_n = 1'b1;
    wait_cyc(cyc + 4);

    // Test 2: full scan, hex 0..7, 100 cycles per digit.
    f0 = frame_cnt;
    t7 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) t7 = cyc;
      run_vec(tbl_a[i], 100, "scan");
    end
    check("scan_frame_cnt", frame_cnt - f0, 1);
    check("scan_frame_lat", frame_cyc - t7, LAT);
    check("scan_valid", {24'd0, bus_if.valid}, 32'hFF);

    // Tests 3 and 5 (segment half): dash+dp, blank, letters, illegal patterns.
    for (int i = 0; i < tbl_b.size(); i++) begin
      run_vec(tbl_b[i], 40, "tbl");
    end

    // Test 4: segment glitches every 10 cycles on digit 3, then steady.
    e0 = err_cnt;
    for (int i = 0; i < 6; i++) begin
      t = cyc;
      drive(8'hF7, ~glitch[i], 1'b1);
      wait_cyc(t + 10);
    end
    check("glitch_d3", {25'd0, bus_if.d3}, 32'h03);
    check("glitch_valid3", {31'd0, bus_if.valid[3]}, 32'h1);
    check("glitch_err", err_cnt - e0, 0);
    t = cyc;
    drive(8'hF7, ~7'h6F, 1'b1);
    wait_cyc(t + LAT - 1);
    check("settle_early_d3", {25'd0, bus_if.d3}, 32'h03);
    wait_cyc(t + LAT);
    check("settle_d3", {25'd0, bus_if.d3}, 32'h09);
    wait_cyc(t + 20);
    check("settle_hold_d3", {25'd0, bus_if.d3}, 32'h09);

    // Test 5 (anode half): two anodes low gives one err and no data change.
    vsnap = bus_if.valid;
    for (int k = 0; k < 8; k++) dsnap[k] = get_d(k);
    e0 = err_cnt;
    t  = cyc;
    drive(8'hFC, ~7'h3F, 1'b1);
    wait_cyc(t + 40);
    check("multi_err", err_cnt - e0, 1);
    check("multi_valid", {24'd0, bus_if.valid}, {24'd0, vsnap});
    for (int k = 0; k < 8; k++) begin
      check($sformatf("multi_d%0d", k), {25'd0, get_d(k)}, {25'd0, dsnap[k]});
    end

    // Test 6: full frame followed by idle lines.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) t7 = cyc;
      run_vec(tbl_a[i], 40, "rescan");
    end
    drive(8'hFF, 7'h7F, 1'b1);
    wait_cyc(t7 + LAT + TO - 1);
    check("idle_pre_valid", {24'd0, bus_if.valid}, 32'hFF);
    wait_cyc(t7 + LAT + TO);
`ifdef SEVENSEG_RX_TIMEOUT_EN
    check("timeout_valid", {24'd0, bus_if.valid}, 32'h00);
`else
    check("idle_valid", {24'd0, bus_if.valid}, 32'hFF);
`endif
    wait_cyc(t7 + LAT + TO + 200);
`ifdef SEVENSEG_RX_TIMEOUT_EN
    check("timeout_hold_valid", {24'd0, bus_if.valid}, 32'h00);
`else
    check("idle_hold_valid", {24'd0, bus_if.valid}, 32'hFF);
`endif
    check("idle_d7", {25'd0, bus_if.d7}, 32'h07);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
